acc_drain: RTL and testbench

Downstream stage of one systolic-array column's accumulators.
- Captures the R final accumulator outputs of the column when upstream flags the last accumulation.
- Serializes them onto an AXI-Stream master (row 0 first, tlast on row R-1).
- Drives the column enable low while a captured result cannot yet be replaced, so accumulators hold under backpressure.

---
 rtl/acc_drain_pkg.sv | 15 +
 rtl/acc_drain_bank.sv | 42 ++++
 rtl/acc_drain.sv | 112 +++++++++++
 tb/tb_acc_drain.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_drain_pkg.sv
// Shared systolic-array types and sizing helpers used by the column drain logic.
package acc_drain_pkg;

    // Drain controller state: bank empty or bank holding a result being streamed.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Row-counter width; at least one bit even for a single-row column.
    function automatic int unsigned cnt_width(input int unsigned rows);
        return (rows < 2) ? 1 : $clog2(rows);
    endfunction

endpackage

// File: rtl/acc_drain_bank.sv
// Shadow bank for one column result: parallel load of all rows, indexed read of one row.
module drain_bank
    import acc_drain_pkg::*;
#(
    parameter int unsigned R      = 4,
    parameter int unsigned WidthY = 16,
    parameter int unsigned CntW   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [R*WidthY-1:0]   d_i,
    input  logic [CntW-1:0]       idx_i,
    output logic [WidthY-1:0]     q_o
);

    logic [WidthY-1:0] bank_q [R];

    // Capture every row at once on load; cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < int'(R); r++) begin
                bank_q[r] <= '0;
            end
        end else if (load_i) begin
            for (int r = 0; r < int'(R); r++) begin
                bank_q[r] <= d_i[r*WidthY +: WidthY];
            end
        end
    end

    // Row select; indices beyond R-1 read as zero so non-power-of-two R stays safe.
    always_comb begin
        q_o = '0;
        for (int r = 0; r < int'(R); r++) begin
            if (idx_i == CntW'(r)) begin
                q_o = bank_q[r];
            end
        end
    end

endmodule

// File: rtl/acc_drain.sv
// Column accumulator drain: captures R final sums and streams them out row 0 first,
// holding the column (en_o low) until the captured result can be replaced.
module acc_drain
    import acc_drain_pkg::*;
#(
    parameter int unsigned R      = 4,
    parameter int unsigned WidthY = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  en_o,
    input  logic                  last_i,
    input  logic [R*WidthY-1:0]   y_i,
    output logic [WidthY-1:0]     m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  overflow_o
);

    localparam int unsigned     CntW    = cnt_width(R);
    localparam logic [CntW-1:0] LastRow = CntW'(R - 1);
    localparam logic            OneRow  = (R == 1);

    drain_state_e      state_q;
    logic [CntW-1:0]   cnt_q;
    logic              at_last_row;
    logic              capture;
    logic              xfer;
    logic [CntW-1:0]   rd_idx;
    logic [WidthY-1:0] rd_word;

    assign at_last_row = (cnt_q == LastRow);

    // Column may advance when the bank is empty or its last word leaves this cycle;
    // m_ready_i is the only input in this path.
    assign en_o = (state_q == IDLE) | ((state_q == DRAIN) & at_last_row & m_ready_i);

    assign capture = last_i & en_o;
    assign xfer    = m_valid_o & m_ready_i;
    assign rd_idx  = cnt_q + CntW'(1);

    drain_bank #(
        .R      (R),
        .WidthY (WidthY),
        .CntW   (CntW)
    ) u_bank (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (capture),
        .d_i    (y_i),
        .idx_i  (rd_idx),
        .q_o    (rd_word)
    );

    // Drain FSM with registered stream outputs and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_valid_o  <= 1'b0;
            m_last_o   <= 1'b0;
            m_data_o   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (last_i && !en_o) begin
                overflow_o <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q   <= DRAIN;
                        cnt_q     <= '0;
                        m_valid_o <= 1'b1;
                        m_data_o  <= y_i[WidthY-1:0];
                        m_last_o  <= OneRow;
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (at_last_row) begin
                            if (capture) begin
                                // Back-to-back result: restart at row 0 with no bubble.
                                cnt_q     <= '0;
                                m_valid_o <= 1'b1;
                                m_data_o  <= y_i[WidthY-1:0];
                                m_last_o  <= OneRow;
                            end else begin
                                state_q   <= IDLE;
                                cnt_q     <= '0;
                                m_valid_o <= 1'b0;
                                m_last_o  <= 1'b0;
                            end
                        end else begin
                            cnt_q    <= rd_idx;
                            m_data_o <= rd_word;
                            m_last_o <= (rd_idx == LastRow);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    m_valid_o <= 1'b0;
                    m_last_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// Scoreboard bench for acc_drain (R=4, WidthY=16).
module tb_acc_drain;

    localparam int unsigned R = 4;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           last_in;
    logic [R*W-1:0] y;
    logic [W-1:0]   mdata;
    logic           mvalid;
    logic           mready;
    logic           mlast;
    logic           ovf;

    beat_t sb[$];
    int    vectors     = 0;
    int    miscompares = 0;

    acc_drain #(.R(R), .WidthY(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_o       (en),
        .last_i     (last_in),
        .y_i        (y),
        .m_data_o   (mdata),
        .m_valid_o  (mvalid),
        .m_ready_i  (mready),
        .m_last_o   (mlast),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [R*W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [R*W-1:0] v;
        v[0*W +: W] = W'(a);
        v[1*W +: W] = W'(b);
        v[2*W +: W] = W'(c);
        v[3*W +: W] = W'(d);
        return v;
    endfunction

    task automatic push_result(input logic [R*W-1:0] v);
        for (int r = 0; r < int'(R); r++) begin
            beat_t b;
            b.data = v[r*W +: W];
            b.last = (r == int'(R) - 1);
            sb.push_back(b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; last_in = 1'b0; y = '0; mready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (mvalid !== 1'b0 || mlast !== 1'b0 || mdata !== '0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b last=%b data=%0d ovf=%b, want 0 0 0 0", mvalid, mlast, mdata, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (mvalid !== 1'b0 || en !== 1'b1 || ovf !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle[%0d]: valid=%b en=%b ovf=%b, want 0 1 0", k, mvalid, en, ovf);
            end
        end
    endtask

    task automatic test_drain();
        logic [R*W-1:0] a;
        int beats;
        a = pack4(5, -3, 127, -128);
        @(negedge clk);
        mready = 1'b1; last_in = 1'b1; y = a; push_result(a);
        #1;
        vectors++;
        if (en !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_capture_en: en=%b want 1", en);
        end
        beats = 0;
        for (int k = 0; k < 12 && beats < 4; k++) begin
            @(negedge clk);
            last_in = 1'b0;
            #1;
            vectors++;
            if (mvalid !== 1'b1 || en !== (beats == 3)) begin
                miscompares++;
                $display("FAIL drain_flow[%0d]: valid=%b en=%b, want 1 %b", k, mvalid, en, beats == 3);
            end
            if (mvalid && mready) begin
                beat_t e;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL drain_beat: unexpected beat %0d", $signed(mdata));
                end else begin
                    e = sb.pop_front();
                    if (mdata !== e.data || mlast !== e.last) begin
                        miscompares++;
                        $display("FAIL drain_beat[%0d]: data=%0d last=%b, want %0d %b",
                                 beats, $signed(mdata), mlast, $signed(e.data), e.last);
                    end
                end
                beats++;
            end
        end
        vectors++;
        if (beats != 4) begin
            miscompares++;
            $display("FAIL drain_count: beats=%0d want 4", beats);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (mvalid !== 1'b0 || mlast !== 1'b0 || en !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_idle: valid=%b last=%b en=%b, want 0 0 1", mvalid, mlast, en);
        end
    endtask

    task automatic test_stall();
        logic [R*W-1:0] a;
        logic [W-1:0]   hold_d;
        logic           hold_l;
        logic           stalled;
        int beats;
        a = pack4(5, -3, 127, -128);
        @(negedge clk);
        mready = 1'b1; last_in = 1'b1; y = a; push_result(a);
        beats = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
        for (int k = 0; k < 40 && beats < 4; k++) begin
            @(negedge clk);
            last_in = 1'b0;
            mready  = (k % 4 == 0) || (k % 4 == 3);
            #1;
            vectors++;
            if (mvalid !== 1'b1 || en !== (beats == 3 && mready)) begin
                miscompares++;
                $display("FAIL stall_flow[%0d]: valid=%b en=%b, want 1 %b", k, mvalid, en, beats == 3 && mready);
            end
            if (stalled) begin
                vectors++;
                if (mdata !== hold_d || mlast !== hold_l) begin
                    miscompares++;
                    $display("FAIL stall_hold[%0d]: data=%0d last=%b, want %0d %b",
                             k, $signed(mdata), mlast, $signed(hold_d), hold_l);
                end
            end
            if (mvalid && mready) begin
                beat_t e;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall_beat: unexpected beat %0d", $signed(mdata));
                end else begin
                    e = sb.pop_front();
                    if (mdata !== e.data || mlast !== e.last) begin
                        miscompares++;
                        $display("FAIL stall_beat[%0d]: data=%0d last=%b, want %0d %b",
                                 beats, $signed(mdata), mlast, $signed(e.data), e.last);
                    end
                end
                beats++;
            end
            stalled = !mready;
            hold_d  = mdata;
            hold_l  = mlast;
        end
        vectors++;
        if (beats != 4) begin
            miscompares++;
            $display("FAIL stall_count: beats=%0d want 4", beats);
        end
        @(negedge clk);
        mready = 1'b1;
        #1;
        vectors++;
        if (mvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_idle: valid=%b want 0", mvalid);
        end
    endtask

    task automatic test_back_to_back();
        logic [R*W-1:0] a;
        logic [R*W-1:0] b;
        int beats;
        int lasts;
        a = pack4(5, -3, 127, -128);
        b = pack4(1, 2, 3, 4);
        @(negedge clk);
        mready = 1'b1; last_in = 1'b1; y = a; push_result(a);
        beats = 0; lasts = 0;
        for (int k = 0; k < 20 && beats < 8; k++) begin
            @(negedge clk);
            last_in = (beats == 3);
            if (beats == 3) begin
                y = b;
                push_result(b);
            end
            #1;
            vectors++;
            if (mvalid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_gap[%0d]: valid=%b want 1", k, mvalid);
            end
            if (mlast) lasts++;
            if (mvalid && mready) begin
                beat_t e;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL b2b_beat: unexpected beat %0d", $signed(mdata));
                end else begin
                    e = sb.pop_front();
                    if (mdata !== e.data || mlast !== e.last) begin
                        miscompares++;
                        $display("FAIL b2b_beat[%0d]: data=%0d last=%b, want %0d %b",
                                 beats, $signed(mdata), mlast, $signed(e.data), e.last);
                    end
                end
                beats++;
            end
        end
        last_in = 1'b0;
        vectors++;
        if (beats != 8 || lasts != 2) begin
            miscompares++;
            $display("FAIL b2b_count: beats=%0d lasts=%0d, want 8 2", beats, lasts);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (mvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: valid=%b want 0", mvalid);
        end
    endtask

    task automatic test_overflow();
        logic [R*W-1:0] a;
        int beats;
        a = pack4(5, -3, 127, -128);
        @(negedge clk);
        mready = 1'b0; last_in = 1'b1; y = a; push_result(a);
        @(negedge clk);
        last_in = 1'b1; y = pack4(9, 9, 9, 9);
        #1;
        vectors++;
        if (en !== 1'b0 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_pre: en=%b ovf=%b, want 0 0", en, ovf);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            last_in = 1'b0;
            #1;
            vectors++;
            if (ovf !== 1'b1 || mvalid !== 1'b1 || mdata !== W'(5)) begin
                miscompares++;
                $display("FAIL ovf_sticky[%0d]: ovf=%b valid=%b data=%0d, want 1 1 5", k, ovf, mvalid, $signed(mdata));
            end
        end
        beats = 0;
        for (int k = 0; k < 12 && beats < 4; k++) begin
            @(negedge clk);
            mready = 1'b1;
            #1;
            if (mvalid && mready) begin
                beat_t e;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL ovf_beat: unexpected beat %0d", $signed(mdata));
                end else begin
                    e = sb.pop_front();
                    if (mdata !== e.data || mlast !== e.last) begin
                        miscompares++;
                        $display("FAIL ovf_beat[%0d]: data=%0d last=%b, want %0d %b",
                                 beats, $signed(mdata), mlast, $signed(e.data), e.last);
                    end
                end
                beats++;
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (beats != 4 || ovf !== 1'b1 || mvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_end: beats=%0d ovf=%b valid=%b, want 4 1 0", beats, ovf, mvalid);
        end
    endtask

    task automatic test_mid_reset();
        logic [R*W-1:0] a;
        logic [R*W-1:0] c;
        int beats;
        a = pack4(5, -3, 127, -128);
        c = pack4(1, 2, 3, 4);
        @(negedge clk);
        mready = 1'b1; last_in = 1'b1; y = a; push_result(a);
        beats = 0;
        for (int k = 0; k < 10 && beats < 2; k++) begin
            @(negedge clk);
            last_in = 1'b0;
            #1;
            if (mvalid && mready) begin
                beat_t e;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL mrst_beat: unexpected beat %0d", $signed(mdata));
                end else begin
                    e = sb.pop_front();
                    if (mdata !== e.data || mlast !== e.last) begin
                        miscompares++;
                        $display("FAIL mrst_beat[%0d]: data=%0d last=%b, want %0d %b",
                                 beats, $signed(mdata), mlast, $signed(e.data), e.last);
                    end
                end
                beats++;
            end
        end
        @(negedge clk);
        rst_n = 1'b0; mready = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (mvalid !== 1'b0 || en !== 1'b1 || ovf !== 1'b0 || mlast !== 1'b0) begin
            miscompares++;
            $display("FAIL mrst_state: valid=%b en=%b ovf=%b last=%b, want 0 1 0 0", mvalid, en, ovf, mlast);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mready = 1'b1;
            #1;
            vectors++;
            if (mvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL mrst_quiet[%0d]: valid=%b want 0", k, mvalid);
            end
        end
        @(negedge clk);
        last_in = 1'b1; y = c; push_result(c);
        beats = 0;
        for (int k = 0; k < 12 && beats < 4; k++) begin
            @(negedge clk);
            last_in = 1'b0;
            #1;
            if (mvalid && mready) begin
                beat_t e;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL mrst_fresh: unexpected beat %0d", $signed(mdata));
                end else begin
                    e = sb.pop_front();
                    if (mdata !== e.data || mlast !== e.last) begin
                        miscompares++;
                        $display("FAIL mrst_fresh[%0d]: data=%0d last=%b, want %0d %b",
                                 beats, $signed(mdata), mlast, $signed(e.data), e.last);
                    end
                end
                beats++;
            end
        end
        vectors++;
        if (beats != 4) begin
            miscompares++;
            $display("FAIL mrst_count: beats=%0d want 4", beats);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
